// File: rtl/irq_concat_n.sv
// irq_concat_n: synchronises CH_NUM interrupt lines, keeps level or sticky rising-edge pending
// bits, and drives a registered masked vector, aggregate and lowest-index ID. Optional: IRQ_CONCAT_OVF_EN.
module irq_concat_n #(
  parameter int                CH_NUM      = 32,
  parameter int                SYNC_STAGES = 2,
  parameter logic [CH_NUM-1:0] EDGE_MASK   = '0,
  localparam int               ID_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] irq_in,
  input  logic [CH_NUM-1:0] irq_en,
  input  logic              clr_we,
  input  logic [CH_NUM-1:0] clr_mask,
`ifdef IRQ_CONCAT_OVF_EN
  output logic [CH_NUM-1:0] irq_ovf,
`endif
  output logic [CH_NUM-1:0] irq_vec,
  output logic              irq_any,
  output logic [ID_W-1:0]   irq_id
);

  logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
  logic [CH_NUM-1:0] sync_d [SYNC_STAGES];
  logic [CH_NUM-1:0] dly_q, dly_d;
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [CH_NUM-1:0] vec_q, vec_d;
  logic              any_q, any_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CH_NUM-1:0] s_last, ev, clr_bits;
`ifdef IRQ_CONCAT_OVF_EN
  logic [CH_NUM-1:0] ovf_q, ovf_d;
`endif

  always_comb begin
    sync_d[0] = irq_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    s_last   = sync_q[SYNC_STAGES-1];
    dly_d    = s_last;
    ev       = s_last & ~dly_q;
    clr_bits = {CH_NUM{clr_we}} & clr_mask;

    // Edge channels: a new event beats a coincident clear so it is never lost.
    pend_d = (EDGE_MASK & (ev | (pend_q & ~clr_bits))) | (~EDGE_MASK & s_last);

`ifdef IRQ_CONCAT_OVF_EN
    // A clear consumes the old event, so it also wins over a fresh overflow.
    ovf_d = EDGE_MASK & ~clr_bits & (ovf_q | (ev & pend_q));
`endif

    vec_d = pend_q & irq_en;
    any_d = |vec_d;
    id_d  = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (vec_d[i]) id_d = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      dly_q  <= '0;
      pend_q <= '0;
      vec_q  <= '0;
      any_q  <= 1'b0;
      id_q   <= '0;
`ifdef IRQ_CONCAT_OVF_EN
      ovf_q  <= '0;
`endif
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      dly_q  <= dly_d;
      pend_q <= pend_d;
      vec_q  <= vec_d;
      any_q  <= any_d;
      id_q   <= id_d;
`ifdef IRQ_CONCAT_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign irq_vec = vec_q;
  assign irq_any = any_q;
  assign irq_id  = id_q;
`ifdef IRQ_CONCAT_OVF_EN
  assign irq_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_irq_concat_n.sv
// tb_irq_concat_n: directed scenarios plus random traffic against a sample-history reference model.
module tb_irq_concat_n;
  localparam int          S    = 2;
  localparam logic [31:0] EDGE = 32'hFFFF_02AD; // ch 0,2,3,5,7,9 and 16..31 edge; ch 4 level

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_in, irq_en, clr_mask, irq_vec;
  logic        clr_we, irq_any;
  logic [4:0]  irq_id;
`ifdef IRQ_CONCAT_OVF_EN
  logic [31:0] irq_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  irq_concat_n #(.CH_NUM(32), .SYNC_STAGES(S), .EDGE_MASK(EDGE)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_en(irq_en),
    .clr_we(clr_we), .clr_mask(clr_mask),
`ifdef IRQ_CONCAT_OVF_EN
    .irq_ovf(irq_ovf),
`endif
    .irq_vec(irq_vec), .irq_any(irq_any), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: hist[k] is the input sampled k+1 edges ago, so the synchronised
  // line seen at this edge is hist[S-1] and its previous value is hist[S].
  logic [31:0] m_hist [0:S];
  logic [31:0] m_pend, m_ovf, e_vec;
  logic        e_any;
  logic [4:0]  e_id;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] v, nxt_pend, nxt_ovf;
    logic        ev, clr;
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) m_hist[k] <= '0;
      m_pend <= '0; m_ovf <= '0; e_vec <= '0; e_any <= 1'b0; e_id <= '0;
    end else begin
      v = m_pend & irq_en;
      e_vec <= v;
      e_any <= (v != 0);
      e_id  <= 5'($clog2(v & (~v + 32'd1)));
      nxt_pend = m_pend;
      nxt_ovf  = m_ovf;
      for (int i = 0; i < 32; i++) begin
        ev  = m_hist[S-1][i] && !m_hist[S][i];
        clr = clr_we && clr_mask[i];
        if (!EDGE[i]) begin
          nxt_pend[i] = m_hist[S-1][i];
          nxt_ovf[i]  = 1'b0;
        end else begin
          if (ev) nxt_pend[i] = 1'b1;
          else if (clr) nxt_pend[i] = 1'b0;
          if (clr) nxt_ovf[i] = 1'b0;
          else if (ev && m_pend[i]) nxt_ovf[i] = 1'b1;
        end
      end
      m_pend <= nxt_pend;
      m_ovf  <= nxt_ovf;
      m_hist[0] <= irq_in;
      for (int k = 1; k <= S; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  always @(negedge clk) begin
    chk("vec", irq_vec, e_vec);
    chk("any", {31'd0, irq_any}, {31'd0, e_any});
    chk("id", {27'd0, irq_id}, {27'd0, e_id});
`ifdef IRQ_CONCAT_OVF_EN
    chk("ovf", irq_ovf, m_ovf);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; irq_en = '1; clr_we = 1'b0; clr_mask = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // level channel 4: latency S+1 after capture edge, same on deassert
    irq_in = 32'h10;
    cyc(S + 1);
    chk("lvl_early", irq_vec, 32'h0);
    cyc(1);
    chk("lvl_vec", irq_vec, 32'h10);
    chk("lvl_id", {27'd0, irq_id}, 32'd4);
    chk("lvl_any", {31'd0, irq_any}, 32'd1);
    irq_in = '0;
    cyc(S + 2);
    chk("lvl_off", irq_vec, 32'h0);

    // edge channel 7 sticky, then cleared
    irq_in = 32'h80; cyc(2); irq_in = '0; cyc(6);
    chk("edge7_sticky", irq_vec, 32'h80);
    clr_we = 1'b1; clr_mask = 32'h80; cyc(1);
    clr_we = 1'b0; clr_mask = '0; cyc(1);
    chk("edge7_clr", irq_vec, 32'h0);

    // masking and re-enable
    irq_en = ~32'h8; irq_in = 32'h208; cyc(2); irq_in = '0; cyc(6);
    chk("mask_id", {27'd0, irq_id}, 32'd9);
    irq_en = '1; cyc(1);
    chk("unmask_id", {27'd0, irq_id}, 32'd3);
    chk("unmask_vec", irq_vec, 32'h208);
    clr_we = 1'b1; clr_mask = 32'h208; cyc(1); clr_we = 1'b0; cyc(2);

    // channel 5 event coincides with clear: set wins
    irq_in = 32'h20; cyc(S);
    clr_we = 1'b1; clr_mask = 32'h20; cyc(1);
    clr_we = 1'b0; clr_mask = '0; cyc(1);
    chk("set_wins", irq_vec & 32'h20, 32'h20);
    irq_in = '0; cyc(2);
    clr_we = 1'b1; clr_mask = 32'h20; cyc(1); clr_we = 1'b0; cyc(2);

    // reset mid-operation with channel 0 held high
    irq_in = 32'h1; cyc(6);
    chk("pre_rst", irq_vec, 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rst_vec", irq_vec, 32'h0);
    chk("rst_any", {31'd0, irq_any}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(S + 1);
    chk("rel_early", irq_vec, 32'h0);
    cyc(1);
    chk("rel_event", irq_vec, 32'h1);
    irq_in = '0; cyc(2);
    clr_we = 1'b1; clr_mask = '1; cyc(1); clr_we = 1'b0; cyc(2);

`ifdef IRQ_CONCAT_OVF_EN
    irq_in = 32'h4; cyc(1); irq_in = '0; cyc(1); irq_in = 32'h4; cyc(1); irq_in = '0; cyc(6);
    chk("ovf_set", irq_ovf, 32'h4);
    clr_we = 1'b1; clr_mask = 32'h4; cyc(1); clr_we = 1'b0; clr_mask = '0; cyc(1);
    chk("ovf_clr", irq_ovf, 32'h0);
    chk("ovf_vec", irq_vec, 32'h0);
`endif

    // random traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      irq_in   = irq_in ^ ($urandom & $urandom & $urandom);
      irq_en   = (n % 200 < 100) ? ($urandom | $urandom) : $urandom;
      clr_we   = ($urandom_range(0, 3) == 0);
      clr_mask = $urandom;
      cyc(1);
    end
    clr_we = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/irq_concat_n.md
# irq_concat_n

Parametrised interrupt concentrator that replaces fixed-width interrupt concat/split wiring in AMBA IP block designs. Takes `CH_NUM` asynchronous interrupt lines and synchronises each one. Each channel is a level or an edge channel; edge channels latch as sticky pending bits until software clears them. The block drives an enabled pending vector, an aggregate interrupt, and a lowest-index priority ID to the CPU interrupt controller.

## Interface
- `CH_NUM`, 32, number of channels, legal range 1..32
- `SYNC_STAGES`, 2, synchroniser depth `S`, legal values 2 or 3
- `EDGE_MASK`, {CH_NUM{1'b0}}, per-channel mode: bit=1 selects rising-edge sticky, bit=0 selects level
- `ID_W`, derived as max(1, $clog2(CH_NUM)); not overridable
- `clk` in 1: single clock for all logic
- `rst_n` in 1: reset, asynchronous assert, active-low
- `irq_in` in CH_NUM: raw interrupt lines, asynchronous to `clk`
- `irq_en` in CH_NUM: per-channel enable, synchronous
- `clr_we` in 1: one-cycle clear strobe
- `clr_mask` in CH_NUM: channels to clear, sampled when `clr_we`=1
- `irq_vec` out CH_NUM: registered (pending & irq_en)
- `irq_any` out 1: registered OR-reduce of `irq_vec`
- `irq_id` out ID_W: registered index of lowest set bit of `irq_vec`; 0 when none is set
- `irq_ovf` out CH_NUM: overflow flags; present only with `IRQ_CONCAT_OVF_EN`

## Operation
- Synchroniser: per channel, `S`-flop chain s[0..S-1] fed from `irq_in`. A delay flop `d` holds the previous s[S-1].
- Edge event: `ev` = s[S-1] & ~d. Only edge channels use `ev`.
- Level channel pending: `pend` <= s[S-1] every cycle. These bits are not sticky, and `clr_we` has no effect on them.
- Edge channel pending:
  - `pend` <= 1 on `ev`.
  - Otherwise `pend` <= 0 when `clr_we` & `clr_mask[i]`.
  - Otherwise `pend` holds.
- Simultaneous `ev` and clear on the same channel: set wins, `pend`=1.
- Masking: `irq_en`=0 hides a channel from the outputs but does not block pending capture. Re-enabling exposes a still-pending bit on the next cycle.
- Output stage, registered from current `pend` and `irq_en`:
  - `irq_vec` = pend & irq_en
  - `irq_any` = |(pend & irq_en)
  - `irq_id` = priority encode of (pend & irq_en), lowest index wins
  - All three outputs update on the same edge.
- Reset (async, any time):
  - Cleared: all sync flops, `d`, `pend`, `irq_ovf`, `irq_vec`, `irq_any`, `irq_id`.
  - On an edge channel, a line held high across reset release produces exactly one `ev`, S cycles after release. This is intended: no event is lost.
- Clearing a level channel, or a channel whose `pend` is already 0, is a no-op.

## Timing
- All outputs are 0 while `rst_n`=0 and on the first edge after release.
- Input latency: `irq_in` rises and is captured at edge 0.
  - s[S-1]=1 after edge S-1.
  - `pend`=1 after edge S.
  - `irq_vec`/`irq_any`/`irq_id` valid after edge S+1, so the latency is S+1 cycles.
- Edge channels need `irq_in` high for at least 1 cycle and low for at least 1 cycle between events. Events narrower than the capture window can be missed; that is not an error.
- Clear latency: `clr_we` at edge N clears `pend` at N; `irq_vec` drops at N+1.
- Enable latency: an `irq_en` change at edge N is reflected in the outputs at N+1.
- Level deassert latency: `irq_in` falls at edge 0; `irq_vec` bit drops after edge S+1.
- `clr_we` held for several cycles clears on every cycle it is high. No handshake or back-pressure.

## Configuration
- `IRQ_CONCAT_OVF_EN` defined:
  - Adds the `irq_ovf` port and a per-channel overflow register.
  - For an edge channel, `ovf` <= 1 when `ev` arrives while `pend` is already 1.
  - `ovf` is cleared by `clr_we` & `clr_mask[i]`.
  - If `ev` and the clear coincide while `pend`=1: `pend` stays 1 and `ovf` clears. The old event is consumed and the new one is held.
  - Level channels: `ovf` is tied 0.
  - Reset value is 0.
- Macro undefined: the port and registers are absent; all other behaviour is identical.

## Test plan
- Reset, S=2, CH_NUM=32, all-level, `irq_en`=all 1s. Drive `irq_in`=0x0000_0010 → `irq_vec`=0x10, `irq_any`=1, `irq_id`=4, exactly 3 cycles after input capture. Deassert → all outputs 0 after 3 cycles.
- Edge channel 7, pulse `irq_in[7]` for 2 cycles → `irq_vec[7]`=1 and stays 1 after the input falls. Pulse `clr_we` with `clr_mask`=0x80 → `irq_vec[7]`=0 one cycle later.
- Edge channels 3 and 9 both pending, `irq_en[3]`=0 → `irq_id`=9. Set `irq_en[3]`=1 → `irq_id`=3 the next cycle; `irq_vec`=0x208.
- Rising edge on channel 5 timed so `pend` sets on the same edge as a `clr_we`/`clr_mask`=0x20 → `pend` stays 1 and `irq_vec[5]`=1.
- Hold edge channel 0 high, pulse `rst_n` low mid-operation → all outputs 0 at once. After release, `irq_vec[0]`=1 at cycle S+1 (one event).
- With `IRQ_CONCAT_OVF_EN`: two edges on channel 2 with no clear → `irq_ovf[2]`=1. Clear with `clr_mask`=0x4 → `irq_ovf[2]`=0 and `irq_vec[2]`=0.
